// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: data RAM, load/store alignment and the MEM/WB register.
// Define MEM_DEBUG_PORT_EN to add a registered second read port (i_debug_addr / o_debug_data).
module mem_access_stage #(
  parameter int BITS_SIZE = 32,
  parameter int BITS_REGS = 5,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_BITS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_valid,
  input  logic [BITS_SIZE-1:0] i_alu,
  input  logic [BITS_SIZE-1:0] i_store_data,
  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic [1:0]           i_size,
  input  logic                 i_zero_extend,
  input  logic                 i_lui,
  input  logic [BITS_SIZE-1:0] i_extension,
  input  logic                 i_mem_to_reg,
  input  logic                 i_reg_write,
  input  logic [BITS_REGS-1:0] i_rd,
  output logic                 o_stall,
  output logic                 o_misaligned,
  output logic [BITS_SIZE-1:0] o_memwb_alu,
  output logic [BITS_SIZE-1:0] o_memwb_dato_mem,
  output logic [BITS_SIZE-1:0] o_memwb_extension,
  output logic [1:0]           o_memwb_size,
  output logic                 o_memwb_zero_extend,
  output logic                 o_memwb_lui,
  output logic                 o_memwb_mem_to_reg,
  output logic                 o_memwb_reg_write,
  output logic [BITS_REGS-1:0] o_memwb_rd
`ifdef MEM_DEBUG_PORT_EN
  ,
  input  logic [ADDR_BITS-1:0] i_debug_addr,
  output logic [BITS_SIZE-1:0] o_debug_data
`endif
);

  typedef enum logic {
    IDLE,
    LOAD_WAIT
  } state_t;

  state_t state;

  logic [BITS_SIZE-1:0] ram [MEM_DEPTH];
  logic [BITS_SIZE-1:0] ram_q;

  logic [ADDR_BITS-1:0] word_idx;
  logic [1:0]           off;
  logic                 mem_op;
  logic                 size_bad;
  logic                 bad_access;
  logic                 store_go;
  logic                 load_go;
  logic [3:0]           byte_en;
  logic [BITS_SIZE-1:0] wdata;

  logic [1:0]           hold_off;
  logic [BITS_SIZE-1:0] hold_alu;
  logic [BITS_SIZE-1:0] hold_extension;
  logic [1:0]           hold_size;
  logic                 hold_zero_extend;
  logic                 hold_lui;
  logic                 hold_mem_to_reg;
  logic                 hold_reg_write;
  logic [BITS_REGS-1:0] hold_rd;

  assign word_idx = i_alu[ADDR_BITS+1:2];
  assign off      = i_alu[1:0];

  always_comb begin
    mem_op   = i_valid && (i_mem_read || i_mem_write);
    size_bad = 1'b0;
    case (i_size)
      2'b00:   size_bad = (off != 2'b00);
      2'b01:   size_bad = 1'b0;
      2'b10:   size_bad = off[0];
      default: size_bad = 1'b1;
    endcase
    bad_access = mem_op && size_bad;
    // Stores win when both flags are set; nothing is issued while held in reset.
    store_go = i_reset_n && (state == IDLE) && i_valid && i_mem_write && !bad_access;
    load_go  = i_reset_n && (state == IDLE) && i_valid && i_mem_read && !i_mem_write && !bad_access;
  end

  always_comb begin
    byte_en = 4'b1111;
    wdata   = i_store_data;
    case (i_size)
      2'b01: begin
        byte_en = 4'b0001 << off;
        wdata   = {4{i_store_data[7:0]}};
      end
      2'b10: begin
        byte_en = 4'b0011 << off;
        wdata   = {2{i_store_data[15:0]}};
      end
      default: begin
        byte_en = 4'b1111;
        wdata   = i_store_data;
      end
    endcase
  end

  assign o_stall = load_go;

  // RAM contents survive reset, so this port carries no reset.
  always_ff @(posedge i_clk) begin
    if (store_go) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          ram[word_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
    if (load_go) begin
      ram_q <= ram[word_idx];
    end
  end

`ifdef MEM_DEBUG_PORT_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_debug_data <= '0;
    end else begin
      o_debug_data <= ram[i_debug_addr];
    end
  end
`endif

  // Loads park their pass-through fields for one cycle while the RAM word comes back.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state               <= IDLE;
      o_misaligned        <= 1'b0;
      o_memwb_alu         <= '0;
      o_memwb_dato_mem    <= '0;
      o_memwb_extension   <= '0;
      o_memwb_size        <= '0;
      o_memwb_zero_extend <= 1'b0;
      o_memwb_lui         <= 1'b0;
      o_memwb_mem_to_reg  <= 1'b0;
      o_memwb_reg_write   <= 1'b0;
      o_memwb_rd          <= '0;
      hold_off            <= '0;
      hold_alu            <= '0;
      hold_extension      <= '0;
      hold_size           <= '0;
      hold_zero_extend    <= 1'b0;
      hold_lui            <= 1'b0;
      hold_mem_to_reg     <= 1'b0;
      hold_reg_write      <= 1'b0;
      hold_rd             <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_misaligned        <= bad_access;
          o_memwb_alu         <= i_alu;
          o_memwb_dato_mem    <= '0;
          o_memwb_extension   <= i_extension;
          o_memwb_size        <= i_size;
          o_memwb_zero_extend <= i_zero_extend;
          o_memwb_lui         <= i_lui;
          o_memwb_mem_to_reg  <= i_mem_to_reg;
          if (load_go) begin
            o_memwb_reg_write <= 1'b0;
            hold_off          <= off;
            hold_alu          <= i_alu;
            hold_extension    <= i_extension;
            hold_size         <= i_size;
            hold_zero_extend  <= i_zero_extend;
            hold_lui          <= i_lui;
            hold_mem_to_reg   <= i_mem_to_reg;
            hold_reg_write    <= i_reg_write;
            hold_rd           <= i_rd;
            state             <= LOAD_WAIT;
          end else begin
            o_memwb_reg_write <= i_valid && i_reg_write && !bad_access;
          end
          o_memwb_rd <= i_rd;
        end
        LOAD_WAIT: begin
          o_misaligned        <= 1'b0;
          o_memwb_alu         <= hold_alu;
          o_memwb_dato_mem    <= ram_q >> {hold_off, 3'b000};
          o_memwb_extension   <= hold_extension;
          o_memwb_size        <= hold_size;
          o_memwb_zero_extend <= hold_zero_extend;
          o_memwb_lui         <= hold_lui;
          o_memwb_mem_to_reg  <= hold_mem_to_reg;
          o_memwb_reg_write   <= hold_reg_write;
          o_memwb_rd          <= hold_rd;
          state               <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed, table-driven bench for mem_access_stage; covers the MEM_DEBUG_PORT_EN port when defined.
module tb_mem_access_stage;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_valid;
  logic [31:0] i_alu;
  logic [31:0] i_store_data;
  logic        i_mem_read;
  logic        i_mem_write;
  logic [1:0]  i_size;
  logic        i_zero_extend;
  logic        i_lui;
  logic [31:0] i_extension;
  logic        i_mem_to_reg;
  logic        i_reg_write;
  logic [4:0]  i_rd;
  logic        o_stall;
  logic        o_misaligned;
  logic [31:0] o_memwb_alu;
  logic [31:0] o_memwb_dato_mem;
  logic [31:0] o_memwb_extension;
  logic [1:0]  o_memwb_size;
  logic        o_memwb_zero_extend;
  logic        o_memwb_lui;
  logic        o_memwb_mem_to_reg;
  logic        o_memwb_reg_write;
  logic [4:0]  o_memwb_rd;
`ifdef MEM_DEBUG_PORT_EN
  logic [7:0]  i_debug_addr;
  logic [31:0] o_debug_data;
`endif

  int assert_count = 0;
  int fail_count   = 0;

  mem_access_stage dut (
    .i_clk               (i_clk),
    .i_reset_n           (i_reset_n),
    .i_valid             (i_valid),
    .i_alu               (i_alu),
    .i_store_data        (i_store_data),
    .i_mem_read          (i_mem_read),
    .i_mem_write         (i_mem_write),
    .i_size              (i_size),
    .i_zero_extend       (i_zero_extend),
    .i_lui               (i_lui),
    .i_extension         (i_extension),
    .i_mem_to_reg        (i_mem_to_reg),
    .i_reg_write         (i_reg_write),
    .i_rd                (i_rd),
    .o_stall             (o_stall),
    .o_misaligned        (o_misaligned),
    .o_memwb_alu         (o_memwb_alu),
    .o_memwb_dato_mem    (o_memwb_dato_mem),
    .o_memwb_extension   (o_memwb_extension),
    .o_memwb_size        (o_memwb_size),
    .o_memwb_zero_extend (o_memwb_zero_extend),
    .o_memwb_lui         (o_memwb_lui),
    .o_memwb_mem_to_reg  (o_memwb_mem_to_reg),
    .o_memwb_reg_write   (o_memwb_reg_write),
    .o_memwb_rd          (o_memwb_rd)
`ifdef MEM_DEBUG_PORT_EN
    ,
    .i_debug_addr        (i_debug_addr),
    .o_debug_data        (o_debug_data)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    string       name;
    logic        valid;
    logic [31:0] alu;
    logic [31:0] sdata;
    logic        rd_en;
    logic        wr_en;
    logic [1:0]  size;
    logic        zext;
    logic        lui;
    logic [31:0] ext;
    logic        m2r;
    logic        regw;
    logic [4:0]  rd;
    logic        e_stall;
    logic        e_mis;
    logic [31:0] e_dato;
    logic        e_regw;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input logic v, input logic [31:0] a,
                              input logic [31:0] sd, input logic r, input logic w,
                              input logic [1:0] sz, input logic zx, input logic [4:0] rd,
                              input logic rw, input logic es, input logic em,
                              input logic [31:0] ed, input logic erw);
    vec_t t;
    t.name    = n;
    t.valid   = v;
    t.alu     = a;
    t.sdata   = sd;
    t.rd_en   = r;
    t.wr_en   = w;
    t.size    = sz;
    t.zext    = zx;
    t.lui     = rd[0];
    t.ext     = {a[15:0], a[31:16]} ^ 32'h0F0F_0F0F;
    t.m2r     = r;
    t.regw    = rw;
    t.rd      = rd;
    t.e_stall = es;
    t.e_mis   = em;
    t.e_dato  = ed;
    t.e_regw  = erw;
    return t;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    assert_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    i_valid       = 1'b0;
    i_alu         = '0;
    i_store_data  = '0;
    i_mem_read    = 1'b0;
    i_mem_write   = 1'b0;
    i_size        = 2'b00;
    i_zero_extend = 1'b0;
    i_lui         = 1'b0;
    i_extension   = '0;
    i_mem_to_reg  = 1'b0;
    i_reg_write   = 1'b0;
    i_rd          = '0;
  endtask

  task automatic check_memwb_zero(input string tag);
    check_output({tag, "_alu"},   o_memwb_alu, 32'h0);
    check_output({tag, "_dato"},  o_memwb_dato_mem, 32'h0);
    check_output({tag, "_ext"},   o_memwb_extension, 32'h0);
    check_output({tag, "_size"},  {30'h0, o_memwb_size}, 32'h0);
    check_output({tag, "_zext"},  {31'h0, o_memwb_zero_extend}, 32'h0);
    check_output({tag, "_lui"},   {31'h0, o_memwb_lui}, 32'h0);
    check_output({tag, "_m2r"},   {31'h0, o_memwb_mem_to_reg}, 32'h0);
    check_output({tag, "_regw"},  {31'h0, o_memwb_reg_write}, 32'h0);
    check_output({tag, "_rd"},    {27'h0, o_memwb_rd}, 32'h0);
    check_output({tag, "_stall"}, {31'h0, o_stall}, 32'h0);
    check_output({tag, "_mis"},   {31'h0, o_misaligned}, 32'h0);
  endtask

  // Drives one vector just after a rising edge and checks MEM/WB once the access has settled.
  task automatic apply_stimulus(input vec_t v);
    i_valid       = v.valid;
    i_alu         = v.alu;
    i_store_data  = v.sdata;
    i_mem_read    = v.rd_en;
    i_mem_write   = v.wr_en;
    i_size        = v.size;
    i_zero_extend = v.zext;
    i_lui         = v.lui;
    i_extension   = v.ext;
    i_mem_to_reg  = v.m2r;
    i_reg_write   = v.regw;
    i_rd          = v.rd;
    #1;
    check_output({v.name, "_stall"}, {31'h0, o_stall}, {31'h0, v.e_stall});
    @(posedge i_clk);
    #1;
    if (v.e_stall) begin
      check_output({v.name, "_bubble_regw"}, {31'h0, o_memwb_reg_write}, 32'h0);
      i_alu        = ~v.alu;
      i_rd         = ~v.rd;
      i_reg_write  = ~v.regw;
      i_mem_write  = 1'b1;
      i_store_data = 32'h0;
      i_extension  = ~v.ext;
      #1;
      check_output({v.name, "_wait_stall"}, {31'h0, o_stall}, 32'h0);
      @(posedge i_clk);
      #1;
    end
    check_output({v.name, "_mis"},  {31'h0, o_misaligned}, {31'h0, v.e_mis});
    check_output({v.name, "_regw"}, {31'h0, o_memwb_reg_write}, {31'h0, v.e_regw});
    if (!v.e_mis) begin
      check_output({v.name, "_dato"}, o_memwb_dato_mem, v.e_dato);
      check_output({v.name, "_alu"},  o_memwb_alu, v.alu);
      check_output({v.name, "_ext"},  o_memwb_extension, v.ext);
      check_output({v.name, "_size"}, {30'h0, o_memwb_size}, {30'h0, v.size});
      check_output({v.name, "_zext"}, {31'h0, o_memwb_zero_extend}, {31'h0, v.zext});
      check_output({v.name, "_lui"},  {31'h0, o_memwb_lui}, {31'h0, v.lui});
      check_output({v.name, "_m2r"},  {31'h0, o_memwb_mem_to_reg}, {31'h0, v.m2r});
      check_output({v.name, "_rd"},   {27'h0, o_memwb_rd}, {27'h0, v.rd});
    end
  endtask

  initial begin
    //               name            v  alu          sdata        r  w  size  zx rd  rw es em dato          erw
    vecs.push_back(mk("st_word",      1, 32'h10,      32'hDEADBEEF, 0, 1, 2'b00, 0, 3,  0, 0, 0, 32'h0,        0));
    vecs.push_back(mk("ld_word",      1, 32'h10,      32'h0,        1, 0, 2'b00, 0, 8,  1, 1, 0, 32'hDEADBEEF, 1));
    vecs.push_back(mk("st_zero",      1, 32'h30,      32'h0,        0, 1, 2'b00, 0, 4,  0, 0, 0, 32'h0,        0));
    vecs.push_back(mk("st_byte",      1, 32'h33,      32'h123456A5, 0, 1, 2'b01, 0, 5,  0, 0, 0, 32'h0,        0));
    vecs.push_back(mk("ld_word_lane", 1, 32'h30,      32'h0,        1, 0, 2'b00, 0, 9,  1, 1, 0, 32'hA5000000, 1));
    vecs.push_back(mk("ld_byte3",     1, 32'h33,      32'h0,        1, 0, 2'b01, 1, 10, 1, 1, 0, 32'h000000A5, 1));
    vecs.push_back(mk("ld_byte2",     1, 32'h32,      32'h0,        1, 0, 2'b01, 0, 11, 1, 1, 0, 32'h0000A500, 1));
    vecs.push_back(mk("st_w20",       1, 32'h20,      32'h11223344, 0, 1, 2'b00, 0, 1,  0, 0, 0, 32'h0,        0));
    vecs.push_back(mk("st_half",      1, 32'h22,      32'hFFFF8001, 0, 1, 2'b10, 0, 2,  1, 0, 0, 32'h0,        1));
    vecs.push_back(mk("ld_half",      1, 32'h22,      32'h0,        1, 0, 2'b10, 1, 12, 1, 1, 0, 32'h00008001, 1));
    vecs.push_back(mk("ld_w20",       1, 32'h20,      32'h0,        1, 0, 2'b00, 0, 13, 1, 1, 0, 32'h80013344, 1));
    vecs.push_back(mk("mis_ld_word",  1, 32'h06,      32'h0,        1, 0, 2'b00, 0, 14, 1, 0, 1, 32'h0,        0));
    vecs.push_back(mk("mis_st_word",  1, 32'h12,      32'h0,        0, 1, 2'b00, 0, 15, 1, 0, 1, 32'h0,        0));
    vecs.push_back(mk("mis_ld_half",  1, 32'h21,      32'h0,        1, 0, 2'b10, 0, 16, 1, 0, 1, 32'h0,        0));
    vecs.push_back(mk("mis_size11",   1, 32'h24,      32'h0,        0, 1, 2'b11, 0, 17, 1, 0, 1, 32'h0,        0));
    vecs.push_back(mk("ld_after_mis", 1, 32'h10,      32'h0,        1, 0, 2'b00, 0, 18, 1, 1, 0, 32'hDEADBEEF, 1));
    vecs.push_back(mk("alu_op",       1, 32'hCAFEF00D, 32'h0,       0, 0, 2'b00, 0, 17, 1, 0, 0, 32'h0,        1));
    vecs.push_back(mk("invalid",      0, 32'h45,      32'h0,        1, 0, 2'b00, 0, 19, 1, 0, 0, 32'h0,        0));
    vecs.push_back(mk("both_flags",   1, 32'h40,      32'h55AA55AA, 1, 1, 2'b00, 0, 20, 1, 0, 0, 32'h0,        1));
    vecs.push_back(mk("ld_40",        1, 32'h40,      32'h0,        1, 0, 2'b00, 0, 21, 1, 1, 0, 32'h55AA55AA, 1));
    vecs.push_back(mk("st_wrap",      1, 32'h444,     32'h0BADC0DE, 0, 1, 2'b00, 0, 22, 0, 0, 0, 32'h0,        0));
    vecs.push_back(mk("ld_wrap",      1, 32'h44,      32'h0,        1, 0, 2'b00, 0, 23, 1, 1, 0, 32'h0BADC0DE, 1));

    drive_idle();
`ifdef MEM_DEBUG_PORT_EN
    i_debug_addr = 8'd0;
`endif
    i_reset_n = 1'b0;
    #2;
    check_memwb_zero("reset");
    #20;
    i_reset_n = 1'b1;
    @(posedge i_clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
    end

    // Misaligned flag must last exactly one cycle.
    i_valid    = 1'b1;
    i_alu      = 32'h06;
    i_mem_read = 1'b1;
    i_size     = 2'b00;
    #1;
    check_output("pulse_stall", {31'h0, o_stall}, 32'h0);
    @(posedge i_clk);
    #1;
    check_output("pulse_hi", {31'h0, o_misaligned}, 32'h1);
    drive_idle();
    @(posedge i_clk);
    #1;
    check_output("pulse_lo", {31'h0, o_misaligned}, 32'h0);

    // Reset while a load sits in LOAD_WAIT discards it.
    i_valid       = 1'b1;
    i_alu         = 32'h10;
    i_mem_read    = 1'b1;
    i_reg_write   = 1'b1;
    i_mem_to_reg  = 1'b1;
    i_rd          = 5'd7;
    i_extension   = 32'h1234_5678;
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b0;
    #1;
    check_memwb_zero("midload_rst");
    #2;
    drive_idle();
    i_reset_n = 1'b1;
    @(posedge i_clk);
    #1;
    check_output("post_rst_regw", {31'h0, o_memwb_reg_write}, 32'h0);
    check_output("post_rst_dato", o_memwb_dato_mem, 32'h0);
    apply_stimulus(mk("ld_post_rst", 1, 32'h10, 32'h0, 1, 0, 2'b00, 0, 24, 1, 1, 0, 32'hDEADBEEF, 1));

`ifdef MEM_DEBUG_PORT_EN
    // Debug read of word 4 alongside a normal load of word 0x30.
    i_debug_addr = 8'd4;
    i_valid      = 1'b1;
    i_alu        = 32'h30;
    i_mem_read   = 1'b1;
    i_reg_write  = 1'b1;
    i_rd         = 5'd25;
    @(posedge i_clk);
    #1;
    check_output("debug_data", o_debug_data, 32'hDEADBEEF);
    drive_idle();
    @(posedge i_clk);
    #1;
    check_output("debug_load_dato", o_memwb_dato_mem, 32'hA5000000);
    check_output("debug_load_rd", {27'h0, o_memwb_rd}, 32'd25);
`endif

    drive_idle();
    @(posedge i_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
